output_collector: RTL and testbench

Downstream stage of the CPU top level. It captures each result word the CPU presents on its `out`/`outFlag` pair into a small FIFO. It then streams the words to the host link as little-endian bytes over a valid/ready handshake. It latches the CPU `endFlag` and asserts `done` once every captured word has been transmitted.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/output_collector.sv | 130 +++++++++++++
 tb/tb_output_collector.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU output collection path.
// Latency: none (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WIDTH_DEF = 36;

    // Number of bytes needed to carry a w-bit word, rounding up.
    function automatic int bytes_for(input int w);
        return (w + 7) / 8;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and extra-bit wrap pointers.
// Latency: a pushed word is visible at rdata and in count on the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module sync_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers differ only in the wrap bit when every slot is occupied.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot this cycle, so a push at full may reuse it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/output_collector.sv
// Captures CPU result words into a FIFO and streams them to the host as little-endian bytes.
// Latency: flag at cycle N gives count=1 at N+1 and the first byte valid at N+2; BYTES+1 cycles per word.
// Backpressure: byteOut holds while byteValid && !byteReady; a word arriving at full FIFO with no pop is dropped.
module output_collector
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 16,
    parameter int ADDRW = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] cpuOut,
    input  logic             cpuOutFlag,
    input  logic             cpuEndFlag,
    output logic [7:0]       byteOut,
    output logic             byteValid,
    input  logic             byteReady,
    output logic [ADDRW:0]   count,
    output logic             overflow,
    output logic             done
);

    localparam int              BYTES = bytes_for(WIDTH);
    localparam int              IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDXW-1:0] LAST  = IDXW'(BYTES - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             end_seen_q, end_seen_d;
    logic             overflow_q, overflow_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             accepting;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (cpuOut),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Once finished, the collector stops listening to the CPU entirely.
    assign accepting = (state_q != DONE);

    // Capture, drop detection and end-of-program latch.
    always_comb begin
        fifo_push  = 1'b0;
        overflow_d = overflow_q;
        end_seen_d = end_seen_q | cpuEndFlag;
        if (cpuOutFlag && accepting) begin
            if (!fifo_full || fifo_pop) begin
                fifo_push = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Serializer next-state: load a word in IDLE, shift out bytes in SEND.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    idx_d    = '0;
                    state_d  = SEND;
                end else if (end_seen_q) begin
                    state_d = DONE;
                end
            end
            SEND: begin
                if (byteReady) begin
                    shift_d = shift_q >> 8;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any word in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            end_seen_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            end_seen_q <= end_seen_d;
            overflow_q <= overflow_d;
        end
    end

    assign byteOut   = shift_q[7:0];
    assign byteValid = (state_q == SEND);
    assign done      = (state_q == DONE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector: vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: host ready driven per vector or per sequence.
module tb_output_collector;

    localparam int WIDTH = 36;
    localparam int DEPTH = 16;
    localparam int ADDRW = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cpuOut;
    logic             cpuOutFlag;
    logic             cpuEndFlag;
    logic [7:0]       byteOut;
    logic             byteValid;
    logic             byteReady;
    logic [ADDRW:0]   count;
    logic             overflow;
    logic             done;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    output_collector #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpuOut     (cpuOut),
        .cpuOutFlag (cpuOutFlag),
        .cpuEndFlag (cpuEndFlag),
        .byteOut    (byteOut),
        .byteValid  (byteValid),
        .byteReady  (byteReady),
        .count      (count),
        .overflow   (overflow),
        .done       (done)
    );

    typedef struct {
        logic        flag;
        logic [35:0] dat;
        logic        rdy;
        logic        vld_e;
        logic [7:0]  byte_e;
        logic [4:0]  cnt_e;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic [35:0] d, input logic r,
                                input logic v, input logic [7:0] b, input logic [4:0] c);
        vec_t t;
        t.flag = f; t.dat = d; t.rdy = r; t.vld_e = v; t.byte_e = b; t.cnt_e = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Record any byte handed over at the coming edge, then advance one cycle.
    task automatic step();
        if (byteValid && byteReady) rx_q.push_back(byteOut);
        tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        cpuOutFlag = 1'b0;
        cpuEndFlag = 1'b0;
        cpuOut     = '0;
        byteReady  = 1'b0;
        tick();
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    function automatic void exp_word(input logic [35:0] w);
        logic [39:0] p;
        p = {4'b0, w};
        for (int k = 0; k < 5; k++) exp_q.push_back(p[k*8 +: 8]);
    endfunction

    task automatic cmp_rx(input string name);
        chk({name, " byte_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            chk($sformatf("%s byte%0d", name, k), 64'(rx_q[k]), 64'(exp_q[k]));
        end
    endtask

    localparam logic [35:0] W0 = 36'h9_1234_5678;
    localparam logic [35:0] WN = 36'hA_BCDE_F012;

    vec_t tbl[18];
    int   last_byte_cyc;
    int   done_cyc;
    int   n;

    initial begin
        // Single word with ready high, then the same word with a 1,0,0,1 ready pattern.
        tbl[0]  = mk(1'b1, W0, 1'b1, 1'b0, 8'h00, 5'd0);
        tbl[1]  = mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 5'd1);
        tbl[2]  = mk(1'b0, '0, 1'b1, 1'b1, 8'h78, 5'd0);
        tbl[3]  = mk(1'b0, '0, 1'b1, 1'b1, 8'h56, 5'd0);
        tbl[4]  = mk(1'b0, '0, 1'b1, 1'b1, 8'h34, 5'd0);
        tbl[5]  = mk(1'b0, '0, 1'b1, 1'b1, 8'h12, 5'd0);
        tbl[6]  = mk(1'b0, '0, 1'b1, 1'b1, 8'h09, 5'd0);
        tbl[7]  = mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 5'd0);
        tbl[8]  = mk(1'b1, W0, 1'b1, 1'b0, 8'h00, 5'd0);
        tbl[9]  = mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 5'd1);
        tbl[10] = mk(1'b0, '0, 1'b1, 1'b1, 8'h78, 5'd0);
        tbl[11] = mk(1'b0, '0, 1'b0, 1'b1, 8'h56, 5'd0);
        tbl[12] = mk(1'b0, '0, 1'b0, 1'b1, 8'h56, 5'd0);
        tbl[13] = mk(1'b0, '0, 1'b1, 1'b1, 8'h56, 5'd0);
        tbl[14] = mk(1'b0, '0, 1'b1, 1'b1, 8'h34, 5'd0);
        tbl[15] = mk(1'b0, '0, 1'b1, 1'b1, 8'h12, 5'd0);
        tbl[16] = mk(1'b0, '0, 1'b1, 1'b1, 8'h09, 5'd0);
        tbl[17] = mk(1'b0, '0, 1'b1, 1'b0, 8'h00, 5'd0);

        do_reset();
        chk("reset byteValid", 64'(byteValid), 64'd0);
        chk("reset byteOut",   64'(byteOut),   64'd0);
        chk("reset count",     64'(count),     64'd0);
        chk("reset overflow",  64'(overflow),  64'd0);
        chk("reset done",      64'(done),      64'd0);

        for (int i = 0; i < 18; i++) begin
            cpuOutFlag = tbl[i].flag;
            cpuOut     = tbl[i].dat;
            byteReady  = tbl[i].rdy;
            chk($sformatf("vec%0d byteValid", i), 64'(byteValid), 64'(tbl[i].vld_e));
            chk($sformatf("vec%0d byteOut", i),   64'(byteOut),   64'(tbl[i].byte_e));
            chk($sformatf("vec%0d count", i),     64'(count),     64'(tbl[i].cnt_e));
            chk($sformatf("vec%0d overflow", i),  64'(overflow),  64'd0);
            chk($sformatf("vec%0d done", i),      64'(done),      64'd0);
            step();
        end
        cpuOutFlag = 1'b0;
        exp_word(W0);
        exp_word(W0);
        cmp_rx("table stream");

        // Fill with ready low. Word 0 is already in the serializer, so words 1..16
        // fill the FIFO and word 17 is the first one dropped.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cpuOutFlag = 1'b1;
            cpuOut     = 36'(i);
            step();
            if (i == 16) begin
                chk("fill count at full", 64'(count), 64'd16);
                chk("fill no overflow yet", 64'(overflow), 64'd0);
            end
        end
        cpuOutFlag = 1'b0;
        chk("fill count saturated", 64'(count), 64'd16);
        chk("fill overflow set", 64'(overflow), 64'd1);
        byteReady = 1'b1;
        for (int c = 0; c < 130; c++) step();
        for (int i = 0; i < 17; i++) exp_word(36'(i));
        cmp_rx("fill stream");
        chk("fill overflow sticky", 64'(overflow), 64'd1);
        chk("fill drained count", 64'(count), 64'd0);

        // Push into a full FIFO in the IDLE cycle that pops the head.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cpuOutFlag = 1'b1;
            cpuOut     = 36'(i);
            step();
        end
        cpuOutFlag = 1'b0;
        chk("popfull pre count", 64'(count), 64'd16);
        byteReady = 1'b1;
        n = 0;
        while (byteValid && n < 20) begin
            step();
            n++;
        end
        chk("popfull idle reached", 64'(byteValid), 64'd0);
        cpuOutFlag = 1'b1;
        cpuOut     = WN;
        step();
        cpuOutFlag = 1'b0;
        chk("popfull count held", 64'(count), 64'd16);
        chk("popfull no overflow", 64'(overflow), 64'd0);
        for (int c = 0; c < 130; c++) step();
        for (int i = 0; i < 17; i++) exp_word(36'(i));
        exp_word(WN);
        cmp_rx("popfull stream");

        // End flag while word 1 is sending; done must follow the last byte by two cycles.
        do_reset();
        byteReady     = 1'b1;
        last_byte_cyc = -1;
        done_cyc      = -1;
        for (int c = 0; c < 40; c++) begin
            cpuOutFlag = (c <= 2) || (c == 25);
            cpuOut     = (c == 0) ? 36'h1_0102_0304 :
                         (c == 1) ? 36'h2_1112_1314 :
                         (c == 2) ? 36'h3_2122_2324 : 36'hF_FFFF_FFFF;
            cpuEndFlag = (c == 9);
            if (c == 9) chk("end during word1", 64'(byteValid), 64'd1);
            if (byteValid && byteReady) last_byte_cyc = c;
            if (done && done_cyc < 0) done_cyc = c;
            step();
        end
        cpuOutFlag = 1'b0;
        cpuEndFlag = 1'b0;
        exp_word(36'h1_0102_0304);
        exp_word(36'h2_1112_1314);
        exp_word(36'h3_2122_2324);
        cmp_rx("end stream");
        chk("end last byte cycle", 64'(last_byte_cyc), 64'd18);
        chk("end done cycle", 64'(done_cyc), 64'd20);
        chk("end done held", 64'(done), 64'd1);
        chk("end ignored count", 64'(count), 64'd0);
        chk("end ignored overflow", 64'(overflow), 64'd0);
        chk("end no valid", 64'(byteValid), 64'd0);

        // Reset while byte 2 of a word is on the bus, with a second word queued.
        do_reset();
        byteReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cpuOutFlag = (c <= 1);
            cpuOut     = (c == 0) ? W0 : 36'h5_5555_5555;
            cpuEndFlag = (c == 2);
            if (c == 4) begin
                chk("rst byte2 showing", 64'(byteOut), 64'h34);
                chk("rst queue nonempty", 64'(count), 64'd1);
                byteReady = 1'b0;
                reset     = 1'b1;
            end
            step();
        end
        reset      = 1'b0;
        byteReady  = 1'b1;
        cpuEndFlag = 1'b0;
        chk("rst after byteValid", 64'(byteValid), 64'd0);
        chk("rst after byteOut", 64'(byteOut), 64'd0);
        chk("rst after count", 64'(count), 64'd0);
        chk("rst after done", 64'(done), 64'd0);
        cpuOutFlag = 1'b1;
        cpuOut     = WN;
        step();
        cpuOutFlag = 1'b0;
        step();
        chk("rst new word first byte", 64'(byteOut), 64'h12);
        for (int c = 0; c < 20; c++) step();
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        exp_word(WN);
        cmp_rx("rst stream");
        chk("rst end cleared", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
